reorder_buffer: RTL and testbench

Circular reorder buffer for the out-of-order core. Sits between the dispatcher/CDB and the architectural register file. It allocates one entry per dispatched instruction and captures results from the ALU and LSB broadcast buses. It retires entries in program order: register writes go to the register file, store release goes to the LSB. On a branch mispredict detected at commit it issues the pipeline-wide flush.

---
 rtl/reorder_buffer_if.sv | 76 +++++++
 rtl/reorder_buffer.sv | 243 ++++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle: dispatcher allocation and operand queries,
// ALU/LSB writeback broadcast, and the commit/flush outputs.
// The reorder buffer connects through the slave modport; the surrounding
// pipeline (dispatcher, CDB, register file, LSB) uses the master modport.
interface reorder_buffer_if #(
  parameter int ROB_ADDR_W = 4
);
  // Dispatcher allocation
  logic                  dispatcher_en_in;
  logic [4:0]            dispatcher_rd_in;
  logic [1:0]            dispatcher_type_in;
  logic [31:0]           dispatcher_pc_in;
  logic                  dispatcher_pred_taken_in;
  logic [ROB_ADDR_W-1:0] dispatcher_tag_out;
  logic                  rob_full_out;

  // Operand queries
  logic [ROB_ADDR_W-1:0] dispatcher_q1_tag_in;
  logic [ROB_ADDR_W-1:0] dispatcher_q2_tag_in;
  logic                  dispatcher_q1_ready_out;
  logic                  dispatcher_q2_ready_out;
  logic [31:0]           dispatcher_q1_value_out;
  logic [31:0]           dispatcher_q2_value_out;

  // ALU writeback
  logic                  cdb_alu_en_in;
  logic [ROB_ADDR_W-1:0] cdb_alu_tag_in;
  logic [31:0]           cdb_alu_value_in;
  logic                  cdb_alu_taken_in;
  logic [31:0]           cdb_alu_target_in;

  // LSB writeback
  logic                  cdb_lsb_en_in;
  logic [ROB_ADDR_W-1:0] cdb_lsb_tag_in;
  logic [31:0]           cdb_lsb_value_in;

  // Commit outputs
  logic                  rob_en_out;
  logic [4:0]            rob_reg_pos_out;
  logic [ROB_ADDR_W-1:0] rob_dest_out;
  logic [31:0]           rob_value_out;
  logic                  lsb_store_commit_out;
  logic [ROB_ADDR_W-1:0] lsb_store_tag_out;
  logic                  rob_flush_out;
  logic [31:0]           rob_jump_pc_out;

  modport slave (
    input  dispatcher_en_in, dispatcher_rd_in, dispatcher_type_in,
           dispatcher_pc_in, dispatcher_pred_taken_in,
           dispatcher_q1_tag_in, dispatcher_q2_tag_in,
           cdb_alu_en_in, cdb_alu_tag_in, cdb_alu_value_in,
           cdb_alu_taken_in, cdb_alu_target_in,
           cdb_lsb_en_in, cdb_lsb_tag_in, cdb_lsb_value_in,
    output dispatcher_tag_out, rob_full_out,
           dispatcher_q1_ready_out, dispatcher_q2_ready_out,
           dispatcher_q1_value_out, dispatcher_q2_value_out,
           rob_en_out, rob_reg_pos_out, rob_dest_out, rob_value_out,
           lsb_store_commit_out, lsb_store_tag_out,
           rob_flush_out, rob_jump_pc_out
  );

  modport master (
    output dispatcher_en_in, dispatcher_rd_in, dispatcher_type_in,
           dispatcher_pc_in, dispatcher_pred_taken_in,
           dispatcher_q1_tag_in, dispatcher_q2_tag_in,
           cdb_alu_en_in, cdb_alu_tag_in, cdb_alu_value_in,
           cdb_alu_taken_in, cdb_alu_target_in,
           cdb_lsb_en_in, cdb_lsb_tag_in, cdb_lsb_value_in,
    input  dispatcher_tag_out, rob_full_out,
           dispatcher_q1_ready_out, dispatcher_q2_ready_out,
           dispatcher_q1_value_out, dispatcher_q2_value_out,
           rob_en_out, rob_reg_pos_out, rob_dest_out, rob_value_out,
           lsb_store_commit_out, lsb_store_tag_out,
           rob_flush_out, rob_jump_pc_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries in program order, captures
// ALU/LSB results, retires one entry per cycle in order and raises the
// pipeline flush on a branch mispredict found at commit.
// Optional feature macro: ROB_CDB_BYPASS_EN -- operand queries also see the
// CDB results broadcast in the same cycle (ALU over LSB). Undefined by default.
module reorder_buffer #(
  parameter int ROB_SIZE   = 16,
  parameter int ROB_ADDR_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  reorder_buffer_if.slave    bus
);

  localparam int DATA_W = 32;
  localparam logic [1:0] TYPE_REG    = 2'b00;
  localparam logic [1:0] TYPE_BRANCH = 2'b01;
  localparam logic [1:0] TYPE_STORE  = 2'b10;
  localparam logic [ROB_ADDR_W:0] FULL_COUNT = (ROB_ADDR_W+1)'(ROB_SIZE);

  // Control state (reset)
  logic [ROB_ADDR_W-1:0] head_q, head_d;
  logic [ROB_ADDR_W-1:0] tail_q, tail_d;
  logic [ROB_ADDR_W:0]   count_q, count_d;
  logic [ROB_SIZE-1:0]   valid_q, valid_d;
  logic [ROB_SIZE-1:0]   ready_q, ready_d;

  // Entry payload (not reset; only read behind valid/ready)
  logic [ROB_SIZE-1:0]   taken_q, taken_d;
  logic [ROB_SIZE-1:0]   pred_q, pred_d;
  logic [1:0]            type_q   [ROB_SIZE];
  logic [1:0]            type_d   [ROB_SIZE];
  logic [4:0]            rd_q     [ROB_SIZE];
  logic [4:0]            rd_d     [ROB_SIZE];
  logic [DATA_W-1:0]     pc_q     [ROB_SIZE];
  logic [DATA_W-1:0]     pc_d     [ROB_SIZE];
  logic [DATA_W-1:0]     value_q  [ROB_SIZE];
  logic [DATA_W-1:0]     value_d  [ROB_SIZE];
  logic [DATA_W-1:0]     target_q [ROB_SIZE];
  logic [DATA_W-1:0]     target_d [ROB_SIZE];

  // Registered commit/flush outputs
  logic                  rob_en_q, rob_en_d;
  logic [4:0]            reg_pos_q, reg_pos_d;
  logic [ROB_ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]     commit_value_q, commit_value_d;
  logic                  store_commit_q, store_commit_d;
  logic [ROB_ADDR_W-1:0] store_tag_q, store_tag_d;
  logic                  flush_q, flush_d;
  logic [DATA_W-1:0]     jump_pc_q, jump_pc_d;

  logic full;
  logic alloc_ok;
  logic commit_ok;
  logic mispredict;

  assign full = (count_q == FULL_COUNT);

  // Next-state: writeback, allocation, in-order commit and mispredict clear
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    taken_d        = taken_q;
    pred_d         = pred_q;
    type_d         = type_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    value_d        = value_q;
    target_d       = target_q;
    rob_en_d       = 1'b0;
    reg_pos_d      = '0;
    dest_d         = '0;
    commit_value_d = '0;
    store_commit_d = 1'b0;
    store_tag_d    = '0;
    flush_d        = 1'b0;
    jump_pc_d      = '0;
    alloc_ok       = 1'b0;
    commit_ok      = 1'b0;
    mispredict     = 1'b0;

    // In the flush-output cycle the buffer is already empty and every
    // dispatch/writeback belongs to squashed work, so nothing is accepted.
    if (!flush_q) begin
      alloc_ok  = bus.dispatcher_en_in && !full;
      commit_ok = valid_q[head_q] && ready_q[head_q];

      // LSB first so that an ALU result to the same tag wins
      if (bus.cdb_lsb_en_in && valid_q[bus.cdb_lsb_tag_in]) begin
        ready_d[bus.cdb_lsb_tag_in] = 1'b1;
        value_d[bus.cdb_lsb_tag_in] = bus.cdb_lsb_value_in;
      end
      if (bus.cdb_alu_en_in && valid_q[bus.cdb_alu_tag_in]) begin
        ready_d[bus.cdb_alu_tag_in]  = 1'b1;
        value_d[bus.cdb_alu_tag_in]  = bus.cdb_alu_value_in;
        taken_d[bus.cdb_alu_tag_in]  = bus.cdb_alu_taken_in;
        target_d[bus.cdb_alu_tag_in] = bus.cdb_alu_target_in;
      end

      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        type_d[tail_q]  = bus.dispatcher_type_in;
        rd_d[tail_q]    = bus.dispatcher_rd_in;
        pc_d[tail_q]    = bus.dispatcher_pc_in;
        pred_d[tail_q]  = bus.dispatcher_pred_taken_in;
        tail_d          = tail_q + 1'b1;
      end

      if (commit_ok) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        case (type_q[head_q])
          TYPE_REG, TYPE_BRANCH: begin
            rob_en_d       = (rd_q[head_q] != 5'd0);
            reg_pos_d      = rd_q[head_q];
            dest_d         = head_q;
            commit_value_d = value_q[head_q];
          end
          TYPE_STORE: begin
            store_commit_d = 1'b1;
            store_tag_d    = head_q;
          end
          default: ;
        endcase
        mispredict = (type_q[head_q] == TYPE_BRANCH) &&
                     (taken_q[head_q] != pred_q[head_q]);
      end

      case ({alloc_ok, commit_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Everything younger than the mispredicted branch is squashed now
      if (mispredict) begin
        flush_d   = 1'b1;
        jump_pc_d = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
        valid_d   = '0;
      end
    end
  end

  // Control state and registered outputs; reset wins over everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      rob_en_q       <= 1'b0;
      reg_pos_q      <= '0;
      dest_q         <= '0;
      commit_value_q <= '0;
      store_commit_q <= 1'b0;
      store_tag_q    <= '0;
      flush_q        <= 1'b0;
      jump_pc_q      <= '0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      rob_en_q       <= rob_en_d;
      reg_pos_q      <= reg_pos_d;
      dest_q         <= dest_d;
      commit_value_q <= commit_value_d;
      store_commit_q <= store_commit_d;
      store_tag_q    <= store_tag_d;
      flush_q        <= flush_d;
      jump_pc_q      <= jump_pc_d;
    end
  end

  // Entry payload storage
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      taken_q  <= taken_d;
      pred_q   <= pred_d;
      type_q   <= type_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      value_q  <= value_d;
      target_q <= target_d;
    end
  end

  logic              q1_ready, q2_ready;
  logic [DATA_W-1:0] q1_value, q2_value;

  // Operand lookup: stored result, optionally overridden by same-cycle CDB
  always_comb begin
    q1_ready = valid_q[bus.dispatcher_q1_tag_in] && ready_q[bus.dispatcher_q1_tag_in];
    q1_value = q1_ready ? value_q[bus.dispatcher_q1_tag_in] : '0;
    q2_ready = valid_q[bus.dispatcher_q2_tag_in] && ready_q[bus.dispatcher_q2_tag_in];
    q2_value = q2_ready ? value_q[bus.dispatcher_q2_tag_in] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (bus.cdb_lsb_en_in && bus.cdb_lsb_tag_in == bus.dispatcher_q1_tag_in) begin
      q1_ready = 1'b1;
      q1_value = bus.cdb_lsb_value_in;
    end
    if (bus.cdb_alu_en_in && bus.cdb_alu_tag_in == bus.dispatcher_q1_tag_in) begin
      q1_ready = 1'b1;
      q1_value = bus.cdb_alu_value_in;
    end
    if (bus.cdb_lsb_en_in && bus.cdb_lsb_tag_in == bus.dispatcher_q2_tag_in) begin
      q2_ready = 1'b1;
      q2_value = bus.cdb_lsb_value_in;
    end
    if (bus.cdb_alu_en_in && bus.cdb_alu_tag_in == bus.dispatcher_q2_tag_in) begin
      q2_ready = 1'b1;
      q2_value = bus.cdb_alu_value_in;
    end
`else
`endif
  end

  assign bus.dispatcher_tag_out      = tail_q;
  assign bus.rob_full_out            = full;
  assign bus.dispatcher_q1_ready_out = q1_ready;
  assign bus.dispatcher_q1_value_out = q1_value;
  assign bus.dispatcher_q2_ready_out = q2_ready;
  assign bus.dispatcher_q2_value_out = q2_value;
  assign bus.rob_en_out              = rob_en_q;
  assign bus.rob_reg_pos_out         = reg_pos_q;
  assign bus.rob_dest_out            = dest_q;
  assign bus.rob_value_out           = commit_value_q;
  assign bus.lsb_store_commit_out    = store_commit_q;
  assign bus.lsb_store_tag_out       = store_tag_q;
  assign bus.rob_flush_out           = flush_q;
  assign bus.rob_jump_pc_out         = jump_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: reset, fill/full, in-order commit,
// mispredict flush, branch outcomes, store release, rdy hold and CDB bypass.
module tb_reorder_buffer;
  localparam int ROB_ADDR_W = 4;
  localparam logic [1:0] T_REG = 2'b00, T_BR = 2'b01, T_ST = 2'b10;
`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int checks = 0;
  int failures = 0;

  reorder_buffer_if #(.ROB_ADDR_W(ROB_ADDR_W)) bus();

  reorder_buffer #(.ROB_SIZE(16), .ROB_ADDR_W(ROB_ADDR_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    bus.dispatcher_en_in = 0; bus.dispatcher_rd_in = 0; bus.dispatcher_type_in = 0;
    bus.dispatcher_pc_in = 0; bus.dispatcher_pred_taken_in = 0;
    bus.dispatcher_q1_tag_in = 0; bus.dispatcher_q2_tag_in = 0;
    bus.cdb_alu_en_in = 0; bus.cdb_alu_tag_in = 0; bus.cdb_alu_value_in = 0;
    bus.cdb_alu_taken_in = 0; bus.cdb_alu_target_in = 0;
    bus.cdb_lsb_en_in = 0; bus.cdb_lsb_tag_in = 0; bus.cdb_lsb_value_in = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_in = 1; tick(); tick(); rst_in = 0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [1:0] ty, input logic [31:0] pc, input logic pred);
    bus.dispatcher_en_in = 1; bus.dispatcher_rd_in = rd; bus.dispatcher_type_in = ty;
    bus.dispatcher_pc_in = pc; bus.dispatcher_pred_taken_in = pred;
    tick();
    bus.dispatcher_en_in = 0;
  endtask

  task automatic alu(input logic en, input logic [3:0] tag, input logic [31:0] v, input logic tk, input logic [31:0] tgt);
    bus.cdb_alu_en_in = en; bus.cdb_alu_tag_in = tag; bus.cdb_alu_value_in = v;
    bus.cdb_alu_taken_in = tk; bus.cdb_alu_target_in = tgt;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL reset_rob_en got=%0h exp=0", bus.rob_en_out); end
    checks++; if (bus.rob_flush_out !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0h exp=0", bus.rob_flush_out); end
    checks++; if (bus.lsb_store_commit_out !== 1'b0) begin failures++; $display("FAIL reset_store got=%0h exp=0", bus.lsb_store_commit_out); end
    checks++; if (bus.dispatcher_tag_out !== 4'd0) begin failures++; $display("FAIL reset_tag got=%0h exp=0", bus.dispatcher_tag_out); end
    checks++; if (bus.rob_full_out !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", bus.rob_full_out); end
    checks++; if ({bus.rob_jump_pc_out, bus.rob_value_out, bus.rob_reg_pos_out, bus.rob_dest_out, bus.lsb_store_tag_out} !== '0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus.rob_jump_pc_out, bus.rob_value_out}); end
    checks++; if ({bus.dispatcher_q1_ready_out, bus.dispatcher_q1_value_out, bus.dispatcher_q2_ready_out, bus.dispatcher_q2_value_out} !== '0) begin
      failures++; $display("FAIL reset_query got=%0h exp=0", bus.dispatcher_q1_ready_out); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), T_REG, 32'h1000 + 32'(i * 4), 1'b0);
      checks++; if (bus.rob_full_out !== (i == 15)) begin failures++; $display("FAIL fill_full[%0d] got=%0h exp=%0h", i, bus.rob_full_out, (i == 15)); end
      checks++; if (bus.dispatcher_tag_out !== 4'(i + 1)) begin failures++; $display("FAIL fill_tag[%0d] got=%0h exp=%0h", i, bus.dispatcher_tag_out, 4'(i + 1)); end
    end
    alloc(5'd31, T_REG, 32'h2000, 1'b0);
    checks++; if (bus.rob_full_out !== 1'b1) begin failures++; $display("FAIL fill_17th_full got=%0h exp=1", bus.rob_full_out); end
    checks++; if (bus.dispatcher_tag_out !== 4'd0) begin failures++; $display("FAIL fill_17th_tag got=%0h exp=0", bus.dispatcher_tag_out); end
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL fill_no_commit got=%0h exp=0", bus.rob_en_out); end
    bus.dispatcher_q1_tag_in = 4'd0;
    #1;
    checks++; if (bus.dispatcher_q1_ready_out !== 1'b0) begin failures++; $display("FAIL fill_q_not_ready got=%0h exp=0", bus.dispatcher_q1_ready_out); end
    rst_in = 1; tick(); rst_in = 0;
    checks++; if (bus.rob_full_out !== 1'b0 || bus.dispatcher_tag_out !== 4'd0) begin
      failures++; $display("FAIL midreset got_full=%0h got_tag=%0h exp=0/0", bus.rob_full_out, bus.dispatcher_tag_out); end
  endtask

  task automatic test_in_order_commit;
    do_reset();
    alloc(5'd5, T_REG, 32'h10, 1'b0);
    alloc(5'd6, T_REG, 32'h14, 1'b0);
    checks++; if (bus.dispatcher_tag_out !== 4'd2) begin failures++; $display("FAIL ioc_tag got=%0h exp=2", bus.dispatcher_tag_out); end
    alu(1, 4'd1, 32'h22, 0, 0); tick();
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL ioc_wait1 got=%0h exp=0", bus.rob_en_out); end
    alu(1, 4'd0, 32'h11, 0, 0); tick();
    alu(0, 0, 0, 0, 0);
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL ioc_wait2 got=%0h exp=0", bus.rob_en_out); end
    bus.dispatcher_q1_tag_in = 4'd1; bus.dispatcher_q2_tag_in = 4'd0; #1;
    checks++; if (bus.dispatcher_q1_ready_out !== 1'b1 || bus.dispatcher_q1_value_out !== 32'h22) begin
      failures++; $display("FAIL ioc_q1 got=%0h/%h exp=1/22", bus.dispatcher_q1_ready_out, bus.dispatcher_q1_value_out); end
    checks++; if (bus.dispatcher_q2_ready_out !== 1'b1 || bus.dispatcher_q2_value_out !== 32'h11) begin
      failures++; $display("FAIL ioc_q2 got=%0h/%h exp=1/11", bus.dispatcher_q2_ready_out, bus.dispatcher_q2_value_out); end
    tick();
    checks++; if ({bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_dest_out, bus.rob_value_out} !== {1'b1, 5'd5, 4'd0, 32'h11}) begin
      failures++; $display("FAIL ioc_commit0 got=%0h/%0d/%0d/%h exp=1/5/0/11", bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_dest_out, bus.rob_value_out); end
    tick();
    checks++; if ({bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_dest_out, bus.rob_value_out} !== {1'b1, 5'd6, 4'd1, 32'h22}) begin
      failures++; $display("FAIL ioc_commit1 got=%0h/%0d/%0d/%h exp=1/6/1/22", bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_dest_out, bus.rob_value_out); end
    tick();
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL ioc_done got=%0h exp=0", bus.rob_en_out); end
    checks++; if (bus.dispatcher_q1_ready_out !== 1'b0) begin failures++; $display("FAIL ioc_retired_q got=%0h exp=0", bus.dispatcher_q1_ready_out); end
  endtask

  task automatic test_mispredict;
    do_reset();
    alloc(5'd0, T_BR, 32'h100, 1'b0);
    alloc(5'd7, T_REG, 32'h104, 1'b0);
    alloc(5'd8, T_REG, 32'h108, 1'b0);
    alloc(5'd9, T_REG, 32'h10c, 1'b0);
    alu(1, 4'd1, 32'h1, 0, 0);
    bus.cdb_lsb_en_in = 1; bus.cdb_lsb_tag_in = 4'd2; bus.cdb_lsb_value_in = 32'h2;
    tick();
    bus.cdb_lsb_en_in = 0;
    alu(1, 4'd3, 32'h3, 0, 0); tick();
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL mp_head_blocks got=%0h exp=0", bus.rob_en_out); end
    alu(1, 4'd0, 32'h0, 1, 32'h200); tick();
    alu(0, 0, 0, 0, 0); tick();
    checks++; if (bus.rob_flush_out !== 1'b1 || bus.rob_jump_pc_out !== 32'h200) begin
      failures++; $display("FAIL mp_flush got=%0h/%h exp=1/200", bus.rob_flush_out, bus.rob_jump_pc_out); end
    checks++; if (bus.rob_en_out !== 1'b0) begin failures++; $display("FAIL mp_rd0 got=%0h exp=0", bus.rob_en_out); end
    checks++; if (bus.dispatcher_tag_out !== 4'd0 || bus.rob_full_out !== 1'b0) begin
      failures++; $display("FAIL mp_cleared got=%0h exp=0", bus.dispatcher_tag_out); end
    bus.dispatcher_en_in = 1; bus.dispatcher_rd_in = 5'd10;
    alu(1, 4'd0, 32'h99, 0, 0);
    tick();
    idle_inputs();
    checks++; if (bus.rob_flush_out !== 1'b0) begin failures++; $display("FAIL mp_pulse_len got=%0h exp=0", bus.rob_flush_out); end
    checks++; if (bus.dispatcher_tag_out !== 4'd0) begin failures++; $display("FAIL mp_alloc_discard got=%0h exp=0", bus.dispatcher_tag_out); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rob_en_out !== 1'b0 || bus.rob_flush_out !== 1'b0) begin
        failures++; $display("FAIL mp_young_commit[%0d] got=%0h exp=0", i, bus.rob_en_out); end
      tick();
    end
    bus.dispatcher_q1_tag_in = 4'd1; #1;
    checks++; if (bus.dispatcher_q1_ready_out !== 1'b0) begin failures++; $display("FAIL mp_young_q got=%0h exp=0", bus.dispatcher_q1_ready_out); end
  endtask

  task automatic test_branch_outcomes;
    do_reset();
    alloc(5'd1, T_BR, 32'h300, 1'b1);
    alu(1, 4'd0, 32'h304, 0, 32'h500); tick();
    alu(0, 0, 0, 0, 0); tick();
    checks++; if (bus.rob_flush_out !== 1'b1 || bus.rob_jump_pc_out !== 32'h304) begin
      failures++; $display("FAIL br_nottaken got=%0h/%h exp=1/304", bus.rob_flush_out, bus.rob_jump_pc_out); end
    checks++; if ({bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_value_out} !== {1'b1, 5'd1, 32'h304}) begin
      failures++; $display("FAIL br_link got=%0h/%0d/%h exp=1/1/304", bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_value_out); end
    tick();
    alloc(5'd2, T_BR, 32'h400, 1'b1);
    alu(1, 4'd0, 32'h404, 1, 32'h480); tick();
    alu(0, 0, 0, 0, 0); tick();
    checks++; if ({bus.rob_flush_out, bus.rob_en_out, bus.rob_reg_pos_out, bus.rob_dest_out} !== {1'b0, 1'b1, 5'd2, 4'd0}) begin
      failures++; $display("FAIL br_correct got=%0h/%0h/%0d exp=0/1/2", bus.rob_flush_out, bus.rob_en_out, bus.rob_reg_pos_out); end
  endtask

  task automatic test_store;
    do_reset();
    alloc(5'd0, T_REG, 32'h0, 1'b0);
    alloc(5'd0, T_REG, 32'h4, 1'b0);
    alloc(5'd0, T_REG, 32'h8, 1'b0);
    alloc(5'd0, T_ST, 32'hc, 1'b0);
    alu(1, 4'd0, 32'h0, 0, 0);
    bus.cdb_lsb_en_in = 1; bus.cdb_lsb_tag_in = 4'd3; bus.cdb_lsb_value_in = 32'h0;
    tick();
    bus.cdb_lsb_en_in = 0;
    for (int i = 0; i < 3; i++) begin
      alu(i < 2, 4'(i + 1), 32'h0, 0, 0);
      tick();
      checks++; if (bus.rob_en_out !== 1'b0 || bus.lsb_store_commit_out !== 1'b0) begin
        failures++; $display("FAIL st_rd0_retire[%0d] got=%0h/%0h exp=0/0", i, bus.rob_en_out, bus.lsb_store_commit_out); end
    end
    alu(0, 0, 0, 0, 0);
    tick();
    checks++; if ({bus.lsb_store_commit_out, bus.lsb_store_tag_out, bus.rob_en_out} !== {1'b1, 4'd3, 1'b0}) begin
      failures++; $display("FAIL st_commit got=%0h/%0d/%0h exp=1/3/0", bus.lsb_store_commit_out, bus.lsb_store_tag_out, bus.rob_en_out); end
    tick();
    checks++; if (bus.lsb_store_commit_out !== 1'b0) begin failures++; $display("FAIL st_pulse got=%0h exp=0", bus.lsb_store_commit_out); end
  endtask

  task automatic test_rdy_hold;
    do_reset();
    rdy_in = 0;
    alloc(5'd4, T_REG, 32'h0, 1'b0);
    rdy_in = 1;
    checks++; if (bus.dispatcher_tag_out !== 4'd0) begin failures++; $display("FAIL rdy_hold got=%0h exp=0", bus.dispatcher_tag_out); end
    alloc(5'd4, T_REG, 32'h0, 1'b0);
    checks++; if (bus.dispatcher_tag_out !== 4'd1) begin failures++; $display("FAIL rdy_resume got=%0h exp=1", bus.dispatcher_tag_out); end
  endtask

  task automatic test_bypass;
    do_reset();
    alloc(5'd3, T_REG, 32'h0, 1'b0);
    alloc(5'd4, T_REG, 32'h4, 1'b0);
    alloc(5'd5, T_REG, 32'h8, 1'b0);
    bus.dispatcher_q1_tag_in = 4'd2;
    alu(1, 4'd2, 32'h55, 0, 0); #1;
    checks++; if (bus.dispatcher_q1_ready_out !== BYP || bus.dispatcher_q1_value_out !== (BYP ? 32'h55 : 32'h0)) begin
      failures++; $display("FAIL byp_alu got=%0h/%h exp=%0h", bus.dispatcher_q1_ready_out, bus.dispatcher_q1_value_out, BYP); end
    tick();
    alu(0, 0, 0, 0, 0); #1;
    checks++; if (bus.dispatcher_q1_ready_out !== 1'b1 || bus.dispatcher_q1_value_out !== 32'h55) begin
      failures++; $display("FAIL byp_stored got=%0h/%h exp=1/55", bus.dispatcher_q1_ready_out, bus.dispatcher_q1_value_out); end
    bus.dispatcher_q2_tag_in = 4'd1;
    alu(1, 4'd1, 32'h66, 0, 0);
    bus.cdb_lsb_en_in = 1; bus.cdb_lsb_tag_in = 4'd1; bus.cdb_lsb_value_in = 32'h77; #1;
    checks++; if (bus.dispatcher_q2_ready_out !== BYP || bus.dispatcher_q2_value_out !== (BYP ? 32'h66 : 32'h0)) begin
      failures++; $display("FAIL byp_priority got=%0h/%h exp=%0h", bus.dispatcher_q2_ready_out, bus.dispatcher_q2_value_out, BYP); end
    alu(0, 0, 0, 0, 0);
    bus.cdb_lsb_tag_in = 4'd0; bus.cdb_lsb_value_in = 32'h88; bus.dispatcher_q2_tag_in = 4'd0; #1;
    checks++; if (bus.dispatcher_q2_ready_out !== BYP || bus.dispatcher_q2_value_out !== (BYP ? 32'h88 : 32'h0)) begin
      failures++; $display("FAIL byp_lsb got=%0h/%h exp=%0h", bus.dispatcher_q2_ready_out, bus.dispatcher_q2_value_out, BYP); end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_in_order_commit();
    test_mispredict();
    test_branch_outcomes();
    test_store();
    test_rdy_hold();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
